instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Multicycle MIPS fetch stage, directly upstream of the control FSM.
//  Owns the PC and the instruction register (IR). Fetches a word from
//  instruction memory over a req/ready handshake and drives the IR
//  (instr[31:0]) that feeds control Opcode.
//  Computes the next PC from control's Jump/Branch plus the ALU zero
//  flag, and advances only when control signals instruction completion.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC after reset; bits [1:0] forced to 0
//  TIMEOUT     16             max cycles waiting for imem_ready before error (>=1)
//  CNT_W       16             width of retired-instruction counter
// PORTS
//  clk          in   1      clock, all state updates on rising edge
//  reset        in   1      synchronous, active-low reset
//  imem_req     out  1      read request to instruction memory
//  imem_addr    out  32     word address = pc
//  imem_rdata   in   32     read data, valid when imem_ready=1
//  imem_ready   in   1      memory completes request this cycle
//  pc_advance   in   1      control: current instruction done, load next PC
//  Jump         in   1      control Jump
//  Branch       in   1      control Branch
//  alu_zero     in   1      ALU zero flag for branch decision
//  pc           out  32     current PC
//  instr        out  32     IR, stable while instr_valid=1 (to control Opcode)
//  instr_valid  out  1      IR holds a fetched instruction
//  fetch_err    out  1      sticky: memory did not respond within TIMEOUT
//  instr_count  out  CNT_W  instructions retired (pc_advance accepted)
// BEHAVIOUR
//  Reset (reset=0 at clk edge): pc=RESET_PC&~3, instr=0 (nop), instr_valid=0,
//   imem_req=0, fetch_err=0, instr_count=0, state=F_IDLE, wait counter=0.
//   Reset wins over every other input, including mid-fetch.
//  FSM states:
//   F_IDLE:  imem_req=0; unconditionally -> F_FETCH next cycle.
//   F_FETCH: imem_req=1, imem_addr=pc; instr_valid=0.
//            imem_ready=1 -> instr<=imem_rdata, wait cnt<=0, -> F_HOLD.
//            else wait cnt++; cnt reaching TIMEOUT-1 with no ready ->
//            fetch_err<=1, -> F_ERR.
//   F_HOLD:  imem_req=0, instr_valid=1, instr held stable.
//            pc_advance=1 -> pc<=next_pc, instr_count++, -> F_FETCH.
//   F_ERR:   imem_req=0, instr_valid=0; leaves only via reset.
//  Latency: ready in first F_FETCH cycle -> instr_valid high the next cycle.
//   pc_advance to new imem_req: 1 cycle.
//  next_pc (32-bit, modulo 2^32, wraps silently):
//   pc4 = pc + 4
//   Jump=1 -> {pc4[31:28], instr[25:0], 2'b00}. Jump has priority over Branch.
//   Branch=1 & alu_zero=1 -> pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}
//   otherwise -> pc4
//  pc_advance, Jump, Branch, alu_zero are sampled only in F_HOLD;
//   ignored in F_IDLE, F_FETCH and F_ERR.
//  imem_ready outside F_FETCH is ignored; imem_rdata is sampled only when
//   both imem_req and imem_ready are 1.
//  instr_count wraps at 2^CNT_W.
//  pc[1:0] is always 2'b00.
// TESTING
//  1 Reset, RESET_PC=0x100, ready=1 immediately, rdata=0x8C220004
//    -> imem_addr=0x100, instr_valid=1 one cycle later, instr=0x8C220004.
//  2 In HOLD at pc=0x100, pc_advance=1, Jump=0, Branch=0
//    -> pc=0x104, instr_count=1, imem_req=1 next cycle.
//  3 pc=0x200, instr=0x1000FFFE, Branch=1, zero=1, advance -> pc=0x1FC;
//    same with zero=0 -> pc=0x204.
//  4 pc=0x3000_0000, instr=0x08000010, Jump=1 and Branch=1, zero=1
//    -> pc=0x3000_0040 (jump wins).
//  5 ready held low for TIMEOUT=16 cycles -> fetch_err=1, imem_req=0, stays
//    until reset=0; ready=1 on cycle 15 -> normal capture, no error.
//  6 reset=0 asserted mid-F_FETCH with ready=1 the same edge -> instr=0,
//    instr_valid=0, pc=RESET_PC. pc=0xFFFF_FFFC, advance -> pc=0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle MIPS fetch stage owning the PC and IR, with a timed imem handshake
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  input  logic             pc_advance,
  input  logic             Jump,
  input  logic             Branch,
  input  logic             alu_zero,
  output logic [31:0]      pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fetch_err,
  output logic [CNT_W-1:0] instr_count
);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {F_IDLE, F_FETCH, F_HOLD, F_ERR} state_t;
  state_t            r_state, w_next_state;
  logic [31:0]       r_pc, r_instr, w_pc4, w_next_pc;
  logic [WAIT_W-1:0] r_wait;
  logic              r_err;
  logic [CNT_W-1:0]  r_count;
  logic              w_capture, w_timeout, w_retire;
  assign w_capture = r_state == F_FETCH && imem_ready;
  assign w_timeout = r_state == F_FETCH && !imem_ready && r_wait == WAIT_W'(TIMEOUT - 1);
  assign w_retire  = r_state == F_HOLD && pc_advance;
  assign w_pc4     = r_pc + 32'd4;
  // Jump outranks a taken branch; both targets keep pc[1:0] at zero
  assign w_next_pc = Jump ? {w_pc4[31:28], r_instr[25:0], 2'b00}
                   : (Branch && alu_zero) ? w_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00}
                   : w_pc4;
  always_ff @(posedge clk) r_state <= !reset ? F_IDLE : w_next_state;
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      F_IDLE:  w_next_state = F_FETCH;
      F_FETCH: w_next_state = w_capture ? F_HOLD : w_timeout ? F_ERR : F_FETCH;
      F_HOLD:  w_next_state = pc_advance ? F_FETCH : F_HOLD;
      default: w_next_state = F_ERR;
    endcase
  end
  always_comb begin
    imem_req    = r_state == F_FETCH;
    instr_valid = r_state == F_HOLD;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= RESET_PC & ~32'h3;
      r_instr <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_capture) r_instr <= imem_rdata;
      r_wait <= w_capture ? '0 : r_state == F_FETCH ? r_wait + 1'b1 : r_wait;
      if (w_timeout) r_err <= 1'b1;
      if (w_retire) begin
        r_pc    <= w_next_pc;
        r_count <= r_count + 1'b1;
      end
    end
  end
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign fetch_err   = r_err;
  assign instr_count = r_count;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for the fetch stage; inputs driven and outputs sampled on negedge
module tb_instr_fetch_unit;
  logic        clk = 0, reset = 0, imem_req, imem_ready = 0;
  logic        pc_advance = 0, Jump = 0, Branch = 0, alu_zero = 0;
  logic [31:0] imem_addr, imem_rdata = 0, pc, instr;
  logic        instr_valid, fetch_err;
  logic [15:0] instr_count;
  int          checks = 0, errors = 0;
  logic [31:0] m_pc, m_instr;
  logic [15:0] m_cnt;
  logic [31:0] q_instr[$];

  instr_fetch_unit #(.RESET_PC(32'h0000_0103), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .pc_advance(pc_advance),
    .Jump(Jump), .Branch(Branch), .alu_zero(alu_zero), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .fetch_err(fetch_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic fetch(input logic [31:0] data, input int delay);
    logic [31:0] exp;
    for (int n = 0; n < 8 && imem_req !== 1'b1; n++) @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fetch_req: imem_req=%b required 1", imem_req); end
    checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, m_pc); end
    imem_ready = 0;
    repeat (delay) @(negedge clk);
    imem_ready = 1; imem_rdata = data; q_instr.push_back(data); m_instr = data;
    @(negedge clk);
    imem_ready = 0; imem_rdata = $urandom;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid: instr_valid=%b required 1", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req: imem_req=%b required 0", imem_req); end
    exp = q_instr.pop_front();
    checks++; if (instr !== exp) begin errors++; $display("FAIL fetch_instr: instr=%h required %h", instr, exp); end
  endtask

  task automatic advance(input logic j, input logic b, input logic z);
    logic [31:0] pc4 = m_pc + 32'd4;
    pc_advance = 1; Jump = j; Branch = b; alu_zero = z;
    m_pc = j ? {pc4[31:28], m_instr[25:0], 2'b00}
         : (b && z) ? pc4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00} : pc4;
    m_cnt++;
    @(negedge clk);
    pc_advance = 0; Jump = 0; Branch = 0; alu_zero = 0;
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL adv_pc: pc=%h required %h", pc, m_pc); end
    checks++; if (instr_count !== m_cnt) begin errors++; $display("FAIL adv_count: instr_count=%0d required %0d", instr_count, m_cnt); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL adv_req: imem_req=%b required 1", imem_req); end
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(negedge clk);
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_pc: pc=%h required 00000100", pc); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: instr=%h required 0", instr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: instr_valid=%b required 0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: imem_req=%b required 0", imem_req); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err: fetch_err=%b required 0", fetch_err); end
    checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL rst_count: instr_count=%0d required 0", instr_count); end
    m_pc = 32'h100; m_cnt = 0; m_instr = 0;
    reset = 1;
  endtask

  task automatic test_first_fetch();
    fetch(32'h8C22_0004, 0);
    checks++; if (instr !== 32'h8C22_0004) begin errors++; $display("FAIL first_instr: instr=%h required 8c220004", instr); end
  endtask

  task automatic test_advance();
    advance(0, 0, 0);
    checks++; if (pc !== 32'h104) begin errors++; $display("FAIL seq_pc: pc=%h required 00000104", pc); end
  endtask

  task automatic test_branch();
    fetch(32'h0800_0080, 0); advance(1, 0, 0);
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL jump_pc: pc=%h required 00000200", pc); end
    fetch(32'h1000_FFFE, 0); advance(0, 1, 1);
    checks++; if (pc !== 32'h1FC) begin errors++; $display("FAIL br_taken: pc=%h required 000001fc", pc); end
    fetch(32'h0800_0080, 1); advance(1, 0, 0);
    fetch(32'h1000_FFFE, 0); advance(0, 1, 0);
    checks++; if (pc !== 32'h204) begin errors++; $display("FAIL br_not_taken: pc=%h required 00000204", pc); end
  endtask

  task automatic test_wrap();
    fetch(32'h1000_FF7D, 0); advance(0, 1, 1);
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL br_back: pc=%h required fffffffc", pc); end
    fetch(32'h0000_0000, 2); advance(0, 0, 0);
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: pc=%h required 00000000", pc); end
  endtask

  task automatic test_jump_priority();
    fetch(32'h1000_FFFD, 0); advance(0, 1, 1);
    fetch(32'h0800_0010, 1); advance(1, 1, 1);
    checks++; if (pc !== 32'hF000_0040) begin errors++; $display("FAIL jump_prio: pc=%h required f0000040", pc); end
  endtask

  task automatic test_timeout();
    fetch(32'hDEAD_BEEF, 15);
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL late_ready_err: fetch_err=%b required 0", fetch_err); end
    advance(0, 0, 0);
    imem_ready = 0; pc_advance = 1; Jump = 1;
    repeat (15) @(negedge clk);
    checks++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL to_early: err=%b req=%b required 0 1", fetch_err, imem_req); end
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL to_ignore_adv: pc=%h required %h", pc, m_pc); end
    @(negedge clk);
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL to_err: err=%b req=%b valid=%b required 1 0 0", fetch_err, imem_req, instr_valid); end
    imem_ready = 1; imem_rdata = 32'h1111_2222;
    repeat (3) @(negedge clk);
    checks++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL err_sticky: err=%b req=%b required 1 0", fetch_err, imem_req); end
    checks++; if (pc !== m_pc || instr !== m_instr) begin errors++; $display("FAIL err_frozen: pc=%h instr=%h required %h %h", pc, instr, m_pc, m_instr); end
    imem_ready = 0; pc_advance = 0; Jump = 0;
  endtask

  task automatic test_reset_mid_fetch();
    reset = 0;
    @(negedge clk);
    checks++; if (fetch_err !== 1'b0 || instr_count !== 16'd0) begin errors++; $display("FAIL err_clear: err=%b count=%0d required 0 0", fetch_err, instr_count); end
    reset = 1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_req: imem_req=%b required 1", imem_req); end
    imem_ready = 1; imem_rdata = 32'h1234_5678; reset = 0;
    @(negedge clk);
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_instr: instr=%h valid=%b required 0 0", instr, instr_valid); end
    checks++; if (pc !== 32'h100 || imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst_pc: pc=%h req=%b required 00000100 0", pc, imem_req); end
    imem_ready = 0; reset = 1;
    m_pc = 32'h100; m_cnt = 0; m_instr = 0;
    fetch(32'hA5A5_A5A5, 0); advance(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_advance();
    test_branch();
    test_wrap();
    test_jump_priority();
    test_timeout();
    test_reset_mid_fetch();
    checks++; if (q_instr.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries required 0", q_instr.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
